iic_bit_engine: RTL and testbench

Bit-level I2C master engine sitting directly downstream of the memory-mapped IIC register block: it consumes one byte command at a time (start/stop/rw flags plus the transmit byte and clock divider) and drives SCL/SDA. It produces START, 8 data bits, ACK slot and STOP with quarter-bit timing. It reports busy, completion, received byte and ACK status back to the register block.

---
 rtl/iic_pkg.sv | 21 ++
 rtl/iic_qtick.sv | 35 +++
 rtl/iic_bit_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_iic_bit_engine.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared types for the IIC bit engine: FSM states, quarter phases,
// and the bit counter width.
package iic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      ACK,
      STOP,
      HOLD
   } state_e;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/iic_qtick.sv
// Quarter-bit prescaler: counts 0..div and ticks on the terminal count.
// load restarts the count at 0; hold freezes the count.
module iic_qtick (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       hold,
   input  logic [7:0] div,
   output logic       tick
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (load) begin
         cnt_d = '0;
      end else if (!hold) begin
         if (cnt_q == div) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/iic_bit_engine.sv
// Bit-level I2C master: START, 8 data bits, ACK slot, STOP in quarter-bit steps.
// Define IIC_CLOCK_STRETCH_EN to let a slave stretch SCL high phases.
module iic_bit_engine
   import iic_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic       cmd_rw,
   input  logic       ack_out,
   input  logic [7:0] tx_data,
   input  logic [7:0] clkdiv,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sck,
   output logic       sda_o,
   output logic       sda_t,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       nack
);

   state_e               state_q, state_d;
   logic [1:0]           qph_q, qph_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]           shreg_q, shreg_d;
   logic [7:0]           rxsh_q, rxsh_d;
   logic [7:0]           div_q, div_d;
   logic                 rw_q, rw_d;
   logic                 stop_q, stop_d;
   logic                 ack_q, ack_d;
   logic                 ack_smp_q, ack_smp_d;
   logic                 sck_q, sck_d;
   logic                 sda_o_q, sda_o_d;
   logic                 sda_t_q, sda_t_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [7:0]           rx_q, rx_d;
   logic                 nack_q, nack_d;

   logic                 idle_like;
   logic                 fin;
   logic                 tick;
   logic                 qt_hold;

   assign idle_like = (state_q == IDLE) || (state_q == HOLD);

`ifdef IIC_CLOCK_STRETCH_EN
   // Released SCL still read low in q1: a slave is stretching the clock.
   assign qt_hold = !idle_like && (qph_q == Q1) && sck_q && !scl_i;
`else
   logic unused_scl;
   assign unused_scl = scl_i;
   assign qt_hold    = 1'b0;
`endif

   iic_qtick u_qtick (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (idle_like),
      .hold    (qt_hold),
      .div     (div_q),
      .tick    (tick)
   );

   always_comb begin
      state_d   = state_q;
      qph_d     = qph_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      rxsh_d    = rxsh_q;
      div_d     = div_q;
      rw_d      = rw_q;
      stop_d    = stop_q;
      ack_d     = ack_q;
      ack_smp_d = ack_smp_q;
      rx_d      = rx_q;
      nack_d    = nack_q;
      done_d    = 1'b0;
      fin       = 1'b0;

      unique case (state_q)
         IDLE, HOLD: begin
            if (cmd_valid) begin
               state_d   = cmd_start ? START : DATA;
               qph_d     = Q0;
               bit_cnt_d = '1;
               shreg_d   = tx_data;
               div_d     = clkdiv;
               rw_d      = cmd_rw;
               stop_d    = cmd_stop;
               ack_d     = ack_out;
            end
         end
         START: begin
            if (tick) begin
               qph_d = qph_q + 2'd1;
               if (qph_q == Q3) state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               qph_d = qph_q + 2'd1;
               if (qph_q == Q2 && rw_q) rxsh_d = {rxsh_q[6:0], sda_i};
               if (qph_q == Q3) begin
                  shreg_d = {shreg_q[6:0], 1'b0};
                  if (bit_cnt_q == '0) state_d = ACK;
                  else bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
               end
            end
         end
         ACK: begin
            if (tick) begin
               qph_d = qph_q + 2'd1;
               if (qph_q == Q2 && !rw_q) ack_smp_d = sda_i;
               if (qph_q == Q3) begin
                  state_d = stop_q ? STOP : HOLD;
                  fin     = !stop_q;
               end
            end
         end
         STOP: begin
            if (tick) begin
               qph_d = qph_q + 2'd1;
               if (qph_q == Q3) begin
                  state_d = IDLE;
                  fin     = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (fin) begin
         done_d = 1'b1;
         if (rw_q) rx_d = rxsh_q;
         else      nack_d = ack_smp_q;
      end
   end

   // Pin levels are decoded from the next state so they change on quarter entry.
   always_comb begin
      sck_d   = 1'b1;
      sda_t_d = 1'b0;
      sda_o_d = 1'b0;
      busy_d  = !((state_d == IDLE) || (state_d == HOLD));

      unique case (state_d)
         IDLE: begin
            sck_d = 1'b1;
         end
         START: begin
            unique case (qph_d)
               Q0: sck_d = sck_q;
               Q1: sck_d = 1'b1;
               Q2: begin
                  sck_d   = 1'b1;
                  sda_t_d = 1'b1;
               end
               default: begin
                  sck_d   = 1'b0;
                  sda_t_d = 1'b1;
               end
            endcase
         end
         DATA: begin
            sck_d   = (qph_d == Q1) || (qph_d == Q2);
            sda_t_d = !rw_d;
            sda_o_d = !rw_d && shreg_d[7];
         end
         ACK: begin
            sck_d   = (qph_d == Q1) || (qph_d == Q2);
            sda_t_d = rw_d;
            sda_o_d = rw_d && ack_d;
         end
         STOP: begin
            sck_d   = (qph_d != Q0);
            sda_t_d = (qph_d == Q0) || (qph_d == Q1);
         end
         HOLD: begin
            sck_d = 1'b0;
         end
         default: begin
            sck_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         qph_q     <= Q0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         rxsh_q    <= '0;
         div_q     <= '0;
         rw_q      <= 1'b0;
         stop_q    <= 1'b0;
         ack_q     <= 1'b0;
         ack_smp_q <= 1'b0;
         sck_q     <= 1'b1;
         sda_o_q   <= 1'b0;
         sda_t_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_q      <= '0;
         nack_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         qph_q     <= qph_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         rxsh_q    <= rxsh_d;
         div_q     <= div_d;
         rw_q      <= rw_d;
         stop_q    <= stop_d;
         ack_q     <= ack_d;
         ack_smp_q <= ack_smp_d;
         sck_q     <= sck_d;
         sda_o_q   <= sda_o_d;
         sda_t_q   <= sda_t_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rx_q      <= rx_d;
         nack_q    <= nack_d;
      end
   end

   assign sck     = sck_q;
   assign sda_o   = sda_o_q;
   assign sda_t   = sda_t_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_q;
   assign nack    = nack_q;

endmodule

// File: tb/tb_iic_bit_engine.sv
// Directed bench for iic_bit_engine: vector table plus reset,
// repeated-START and clock-stretch sequences.
module tb_iic_bit_engine;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cmd_valid, cmd_start, cmd_stop, cmd_rw, ack_out;
   logic [7:0] tx_data, clkdiv;
   logic       scl_i, sda_i;
   logic       sck, sda_o, sda_t, busy, done, nack;
   logic [7:0] rx_data;

   always #5 clk = ~clk;

   iic_bit_engine dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_start (cmd_start),
      .cmd_stop  (cmd_stop),
      .cmd_rw    (cmd_rw),
      .ack_out   (ack_out),
      .tx_data   (tx_data),
      .clkdiv    (clkdiv),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .sck       (sck),
      .sda_o     (sda_o),
      .sda_t     (sda_t),
      .busy      (busy),
      .done      (done),
      .rx_data   (rx_data),
      .nack      (nack)
   );

   int n_vec = 0;
   int n_err = 0;

   // slave model: timed from the accept edge, slot = 4 quarters
   int         clk_cnt = 0;
   int         acc_cnt = 0;
   logic       slv_en = 1'b0;
   logic       slv_rd = 1'b0;
   logic       slv_ack = 1'b0;
   logic [7:0] slv_byte = 8'h00;
   int         slv_off = 0;
   int         slv_div = 0;
   logic       scl_low = 1'b0;
   int         qi, slot;
   logic       slv_sda;

   always @(posedge clk) clk_cnt <= clk_cnt + 1;

   always_comb begin
      slv_sda = 1'b1;
      qi      = 0;
      slot    = 0;
      if (slv_en) begin
         qi = (clk_cnt - acc_cnt) / (slv_div + 1);
         if (qi >= slv_off) begin
            slot = (qi - slv_off) / 4;
            if (slv_rd && slot < 8) slv_sda = slv_byte[7-slot];
            else if (!slv_rd && slot == 8 && slv_ack) slv_sda = 1'b0;
         end
      end
   end

   assign sda_i = (sda_t && !sda_o) ? 1'b0 : slv_sda;
   assign scl_i = scl_low ? 1'b0 : sck;

   // bus monitor
   logic rise_bus[$];
   logic rise_t[$];
   int   evf = 0, evr = 0;
   int   clr_gen = 0, clr_seen = 0;
   logic prev_sck = 1'b1, prev_sda = 1'b1;

   always @(negedge clk) begin
      if (clr_seen != clr_gen) begin
         rise_bus.delete();
         rise_t.delete();
         evf      <= 0;
         evr      <= 0;
         clr_seen <= clr_gen;
      end else begin
         if (sck && !prev_sck) begin
            rise_bus.push_back(sda_i);
            rise_t.push_back(sda_t);
         end
         if (sck && prev_sck && sda_i != prev_sda) begin
            if (sda_i) evr <= evr + 1;
            else       evf <= evf + 1;
         end
      end
      prev_sck <= sck;
      prev_sda <= sda_i;
   end

   typedef struct {
      logic       st, sp, rw, ao;
      logic [7:0] tx, div;
      logic       s_en;
      logic [7:0] s_byte;
      logic       s_ack;
      int         e_cyc;
      logic [7:0] e_rx;
      logic       e_nack, e_sck;
      logic [7:0] e_data;
      logic [1:0] e_ack;
      int         e_evf, e_evr;
   } vec_t;

   vec_t vt[5];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic issue(input vec_t v);
      slv_en    = 1'b0;
      cmd_start = v.st;
      cmd_stop  = v.sp;
      cmd_rw    = v.rw;
      ack_out   = v.ao;
      tx_data   = v.tx;
      clkdiv    = v.div;
      cmd_valid = 1'b1;
      clr_gen++;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      acc_cnt   = clk_cnt;
      slv_rd    = v.rw;
      slv_byte  = v.s_byte;
      slv_ack   = v.s_ack;
      slv_off   = v.st ? 4 : 0;
      slv_div   = int'(v.div);
      slv_en    = v.s_en;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         if (done) break;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int         n, ackv;
      logic [7:0] d;
      issue(v);
      wait_done(n);
      chk({tag, " cycles"}, n, v.e_cyc);
      chk({tag, " nack"}, int'(nack), int'(v.e_nack));
      chk({tag, " rx_data"}, int'(rx_data), int'(v.e_rx));
      chk({tag, " sck_end"}, int'(sck), int'(v.e_sck));
      chk({tag, " busy_end"}, int'(busy), 0);
      chk({tag, " rises"}, rise_bus.size(), 9 + (v.sp ? 1 : 0));
      d = '0;
      for (int i = 0; i < 8; i++)
         if (i < rise_bus.size()) d[7-i] = rise_bus[i];
      chk({tag, " data"}, int'(d), int'(v.e_data));
      ackv = -1;
      if (rise_bus.size() > 8) ackv = int'({rise_t[8], rise_bus[8]});
      chk({tag, " ack_slot"}, ackv, int'(v.e_ack));
      chk({tag, " sda_fall_hi"}, evf, v.e_evf);
      chk({tag, " sda_rise_hi"}, evr, v.e_evr);
      @(posedge clk);
      #1;
      chk({tag, " done_width"}, int'(done), 0);
   endtask

   initial begin
      int         n;
      logic [7:0] d;
      vec_t       v;

      //        st sp rw ao tx     div   en s_byte s_ack cyc rx    nk sck data   ack    f  r
      vt[0] = '{1, 1, 0, 0, 8'hA5, 8'd1, 1, 8'h00, 1, 88,  8'h00, 0, 1, 8'hA5, 2'b00, 1, 1};
      vt[1] = '{1, 0, 0, 0, 8'h5A, 8'd0, 1, 8'h00, 1, 40,  8'h00, 0, 0, 8'h5A, 2'b00, 1, 0};
      vt[2] = '{0, 0, 1, 1, 8'h00, 8'd1, 1, 8'h3C, 0, 72,  8'h3C, 0, 0, 8'h3C, 2'b11, 0, 0};
      vt[3] = '{0, 1, 0, 0, 8'h96, 8'd2, 0, 8'h00, 0, 120, 8'h3C, 1, 1, 8'h96, 2'b01, 0, 1};
      vt[4] = '{1, 1, 1, 0, 8'h00, 8'd0, 1, 8'hC3, 0, 44,  8'hC3, 1, 1, 8'hC3, 2'b10, 1, 1};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_start = 1'b0;
      cmd_stop  = 1'b0;
      cmd_rw    = 1'b0;
      ack_out   = 1'b0;
      tx_data   = 8'h00;
      clkdiv    = 8'h00;
      #22;
      chk("rst sck", int'(sck), 1);
      chk("rst sda_o", int'(sda_o), 0);
      chk("rst sda_t", int'(sda_t), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst rx_data", int'(rx_data), 0);
      chk("rst nack", int'(nack), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // reset in the middle of data bit 4
      issue(vt[0]);
      repeat (42) begin
         @(posedge clk);
         #1;
      end
      chk("midrst busy_before", int'(busy), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst sck", int'(sck), 1);
      chk("midrst sda_t", int'(sda_t), 0);
      chk("midrst sda_o", int'(sda_o), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst done", int'(done), 0);
      chk("midrst rx_data", int'(rx_data), 0);
      chk("midrst nack", int'(nack), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      slv_en  = 1'b0;
      @(posedge clk);
      #1;
      run_vec(vt[0], "postrst");

      // repeated START from HOLD, with a strobe and divider change while busy
      run_vec(vt[1], "pre_rs");
      issue(vt[0]);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b1;
      cmd_rw    = 1'b1;
      cmd_start = 1'b0;
      tx_data   = 8'h00;
      clkdiv    = 8'd0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_done(n);
      chk("rs cycles", n + 11, 88);
      chk("rs nack", int'(nack), 0);
      chk("rs rises", rise_bus.size(), 11);
      chk("rs sda_hi_at_scl_rise", (rise_bus.size() > 0) ? int'(rise_bus[0]) : -1, 1);
      d = '0;
      for (int i = 1; i < 9; i++)
         if (i < rise_bus.size()) d[8-i] = rise_bus[i];
      chk("rs data", int'(d), 8'hA5);
      chk("rs sda_fall_hi", evf, 1);
      chk("rs sda_rise_hi", evr, 1);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      chk("rs ignored_busy", int'(busy), 0);
      chk("rs idle_sck", int'(sck), 1);

      // SCL held low for 20 clocks in bit 2 high phase
      v      = vt[0];
      v.s_en = 1'b0;
      issue(v);
      repeat (26) begin
         @(posedge clk);
         #1;
      end
      scl_low = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      scl_low = 1'b0;
      wait_done(n);
`ifdef IIC_CLOCK_STRETCH_EN
      chk("stretch cycles", n + 46, 108);
`else
      chk("stretch cycles", n + 46, 88);
`endif
      chk("stretch nack", int'(nack), 1);
      d = '0;
      for (int i = 0; i < 8; i++)
         if (i < rise_bus.size()) d[7-i] = rise_bus[i];
      chk("stretch data", int'(d), 8'hA5);
      chk("stretch sda_fall_hi", evf, 1);
      chk("stretch sda_rise_hi", evr, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
